// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RV64 core: datapath width, ALUOp
// encodings, major opcodes and the decoded control bundle.
package core_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load sitting in EX and the
// instruction being decoded in ID. Purely combinational.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (ex_rd == id_rs1);
  // Only R-type, store and branch actually read rs2; I-type/load reuse the field.
  assign rs2_hit = (ex_rd == id_rs2) & (~id_alu_src | id_mem_write);

  assign lu = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: registers control and operands into EX, inserts
// bubbles on load-use hazard or flush, and counts inserted bubbles.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_MemRead,
  input  logic             id_MemToReg,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc,
  input  logic             id_RegWrite,
  input  logic [1:0]       id_ALUOp,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_MemRead,
  output logic             ex_MemToReg,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc,
  output logic             ex_RegWrite,
  output logic [1:0]       ex_ALUOp,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count
);

  import core_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ctrl_t            id_ctrl;
  ctrl_t            ctrl_p1;
  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [XLEN-1:0]  rs1_data_p1;
  logic [XLEN-1:0]  rs2_data_p1;
  logic [XLEN-1:0]  imm_p1;
  logic [4:0]       rs1_p1;
  logic [4:0]       rs2_p1;
  logic [4:0]       rd_p1;
  logic [3:0]       funct_p1;
  logic [CNT_W-1:0] bubble_cnt;
  logic             lu;
  logic             load_bubble;

  always_comb begin
    id_ctrl            = CTRL_NOP;
    id_ctrl.branch     = id_branch;
    id_ctrl.mem_read   = id_MemRead;
    id_ctrl.mem_to_reg = id_MemToReg;
    id_ctrl.alu_op     = id_ALUOp;
    id_ctrl.mem_write  = id_MemWrite;
    id_ctrl.alu_src    = id_ALUSrc;
    id_ctrl.reg_write  = id_RegWrite;
  end

  hazard_detect u_hazard (
    .ex_valid     (vld_p1),
    .ex_mem_read  (ctrl_p1.mem_read),
    .ex_rd        (rd_p1),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_alu_src   (id_ALUSrc),
    .id_mem_write (id_MemWrite),
    .lu           (lu)
  );

  assign stall       = lu & ~flush;
  assign load_bubble = flush | lu;

  // ID -> EX boundary; a flush must land even while the pipe is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= CTRL_NOP;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      funct_p1    <= '0;
      bubble_cnt  <= '0;
    end else if (flush | ~hold) begin
      pc_p1       <= id_pc;
      rs1_data_p1 <= id_rs1_data;
      rs2_data_p1 <= id_rs2_data;
      imm_p1      <= id_imm;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rd_p1       <= id_rd;
      funct_p1    <= id_funct;
      if (load_bubble) begin
        vld_p1     <= 1'b0;
        ctrl_p1    <= CTRL_NOP;
        bubble_cnt <= sat_inc(bubble_cnt);
      end else begin
        vld_p1     <= id_valid;
        ctrl_p1    <= id_valid ? id_ctrl : CTRL_NOP;
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_branch    = ctrl_p1.branch;
  assign ex_MemRead   = ctrl_p1.mem_read;
  assign ex_MemToReg  = ctrl_p1.mem_to_reg;
  assign ex_ALUOp     = ctrl_p1.alu_op;
  assign ex_MemWrite  = ctrl_p1.mem_write;
  assign ex_ALUSrc    = ctrl_p1.alu_src;
  assign ex_RegWrite  = ctrl_p1.reg_write;
  assign ex_pc        = pc_p1;
  assign ex_rs1_data  = rs1_data_p1;
  assign ex_rs2_data  = rs2_data_p1;
  assign ex_imm       = imm_p1;
  assign ex_rs1       = rs1_p1;
  assign ex_rs2       = rs2_p1;
  assign ex_rd        = rd_p1;
  assign ex_funct     = funct_p1;
  assign bubble_count = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected stall and EX
// state computed from a behavioural model; a monitor pops and compares.
module tb_id_ex_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             id_valid, id_branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [1:0]       id_ALUOp;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [3:0]       id_funct;
  logic             flush, hold;
  logic             ex_valid, ex_branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [1:0]       ex_ALUOp;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [3:0]       ex_funct;
  logic             stall;
  logic [CNT_W-1:0] bubble_count;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_branch(id_branch), .id_MemRead(id_MemRead),
    .id_MemToReg(id_MemToReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
    .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_MemRead(ex_MemRead),
    .ex_MemToReg(ex_MemToReg), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall(stall), .bubble_count(bubble_count)
  );

  // Control vector order: branch, MemRead, MemToReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite
  localparam logic [7:0] C_LD   = 8'b0110_0011;
  localparam logic [7:0] C_ADD  = 8'b0001_0001;
  localparam logic [7:0] C_ADDI = 8'b0000_0011;
  localparam logic [7:0] C_SD   = 8'b0000_0110;

  typedef struct packed {
    logic             valid;
    logic [7:0]       ctl;
    logic [XLEN-1:0]  pc, rs1d, rs2d, imm;
    logic [4:0]       rs1, rs2, rd;
    logic [3:0]       funct;
    logic [CNT_W-1:0] cnt;
  } ex_t;

  ex_t  m;
  ex_t  state_q[$];
  logic stall_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic instr(input logic [7:0] c, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid = 1'b1;
    {id_branch, id_MemRead, id_MemToReg, id_ALUOp, id_MemWrite, id_ALUSrc, id_RegWrite} = c;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_pc = {$urandom, $urandom}; id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_funct = 4'($urandom);
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic rand_inputs();
    instr(8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    id_valid = ($urandom_range(0, 7) != 0);
    flush    = ($urandom_range(0, 9) == 0);
    hold     = ($urandom_range(0, 6) == 0);
  endtask

  // Apply the current ID inputs for one clock; model the edge from the rules.
  task automatic cycle();
    logic reads_rs2, lu;
    ex_t  nx;
    reads_rs2 = !id_ALUSrc || id_MemWrite;
    lu = m.valid && m.ctl[6] && (m.rd != 5'd0) && id_valid &&
         ((m.rd == id_rs1) || (reads_rs2 && m.rd == id_rs2));
    stall_q.push_back(lu && !flush);
    nx = m;
    if (flush || !hold) begin
      nx.pc = id_pc; nx.rs1d = id_rs1_data; nx.rs2d = id_rs2_data; nx.imm = id_imm;
      nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd; nx.funct = id_funct;
      if (flush || lu) begin
        nx.valid = 1'b0;
        nx.ctl   = 8'h00;
        if (m.cnt != {CNT_W{1'b1}}) nx.cnt = m.cnt + 1'b1;
      end else begin
        nx.valid = id_valid;
        nx.ctl   = id_valid ? {id_branch, id_MemRead, id_MemToReg, id_ALUOp, id_MemWrite, id_ALUSrc, id_RegWrite} : 8'h00;
      end
    end
    m = nx;
    state_q.push_back(m);
    @(posedge clk); #2;
  endtask

  // Monitor: stall sampled mid-cycle, registered state just after the edge.
  initial begin
    ex_t  e;
    logic s;
    forever begin
      @(negedge clk);
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        chk("stall", {63'd0, stall}, {63'd0, s});
      end
      @(posedge clk); #1;
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
        chk("ex_ctrl", {56'd0, ex_branch, ex_MemRead, ex_MemToReg, ex_ALUOp, ex_MemWrite, ex_ALUSrc, ex_RegWrite},
            {56'd0, e.ctl});
        chk("bubble_count", {60'd0, bubble_count}, {60'd0, e.cnt});
        if (e.valid) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rs1_data", ex_rs1_data, e.rs1d);
          chk("ex_rs2_data", ex_rs2_data, e.rs2d);
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_idx", {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct}, {45'd0, e.rs1, e.rs2, e.rd, e.funct});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
    chk({tag, "_ctrl"}, {56'd0, ex_branch, ex_MemRead, ex_MemToReg, ex_ALUOp, ex_MemWrite, ex_ALUSrc, ex_RegWrite}, 64'd0);
    chk({tag, "_data"}, ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 64'd0);
    chk({tag, "_idx"}, {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct}, 64'd0);
    chk({tag, "_count"}, {60'd0, bubble_count}, 64'd0);
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    instr(8'h00, 5'd0, 5'd0, 5'd0);
    id_valid = 1'b0;
    m = '0;
    @(posedge clk); #2;
    check_reset_state("reset");
    reset = 1'b0;

    // ld x5 followed by dependent add: one bubble, then the add enters EX
    instr(C_LD, 5'd1, 5'd0, 5'd5);   cycle();
    instr(C_ADD, 5'd5, 5'd7, 5'd6);  cycle();
    cycle();

    // addi reuses rs2 field without reading it; sd really reads rs2
    instr(C_LD, 5'd1, 5'd0, 5'd5);   cycle();
    instr(C_ADDI, 5'd0, 5'd5, 5'd6); cycle();
    instr(C_LD, 5'd1, 5'd0, 5'd5);   cycle();
    instr(C_SD, 5'd2, 5'd5, 5'd0);   cycle();
    cycle();

    // load to x0 never hazards
    instr(C_LD, 5'd1, 5'd0, 5'd0);   cycle();
    instr(C_ADD, 5'd0, 5'd0, 5'd1);  cycle();

    // flush with hazard and hold: one bubble, no stall
    instr(C_LD, 5'd1, 5'd0, 5'd5);   cycle();
    instr(C_ADD, 5'd5, 5'd5, 5'd6);
    flush = 1'b1; hold = 1'b1;       cycle();

    // hold three cycles with changing ID inputs
    instr(C_ADD, 5'd3, 5'd4, 5'd9);  cycle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); flush = 1'b0; hold = 1'b1; cycle();
    end

    // drive the counter into saturation, then add a load-use bubble
    for (int i = 0; i < 18; i++) begin
      rand_inputs(); flush = 1'b1; cycle();
    end
    instr(C_LD, 5'd1, 5'd0, 5'd5);   cycle();
    instr(C_ADD, 5'd5, 5'd2, 5'd6);  cycle();

    // asynchronous reset mid-stall with a load in EX
    instr(C_LD, 5'd1, 5'd0, 5'd5);   cycle();
    instr(C_ADD, 5'd5, 5'd2, 5'd6);
    #1;
    chk("pre_reset_stall", {63'd0, stall}, 64'd1);
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk); #2;
    reset = 1'b0;
    m = '0;

    for (int i = 0; i < 500; i++) begin
      rand_inputs(); cycle();
    end

    for (int i = 0; i < 10 && (stall_q.size() > 0 || state_q.size() > 0); i++) @(posedge clk);
    if (stall_q.size() > 0 || state_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", stall_q.size() + state_q.size());
    end
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
